// File: rtl/module_period_meter_pkg.sv
// Shared types and defaults for the period meter.
package module_period_meter_pkg;

   // Measurement FSM states.
   typedef enum logic [1:0] {
      S_WAIT_LOW,
      S_WAIT_EDGE,
      S_MEASURE,
      S_TIMEOUT
   } state_t;

   // Default timeout limit / largest reportable period, in clk cycles.
   localparam int DEFAULT_MAX_COUNT = 4000000;

endpackage

// File: rtl/module_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input, followed by an edge
// detector working on the synchronized level. SYNC_STAGES must be >= 2.
module module_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level_out,
   output logic rise_out,
   output logic fall_out
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the input through the synchronizer and keep one delayed copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_out = sync_q[SYNC_STAGES-1];
   assign rise_out  = level_out & ~prev_q;
   assign fall_out  = ~level_out & prev_q;

endmodule

// File: rtl/module_period_meter.sv
// Period / high-time meter for a slow periodic input. Reports both in clk
// cycles with a one-cycle valid strobe per completed period, and raises a
// timeout level when no rising edge arrives within MAX_COUNT cycles.
//
// Handshake: valid_out is a pure one-cycle strobe with no ready; period_out
// and high_out change only in the cycle valid_out is high and hold otherwise.
module module_period_meter
   import module_period_meter_pkg::*;
#(
   parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = $clog2(MAX_COUNT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period_out,
   output logic [WIDTH-1:0] high_out,
   output logic             valid_out,
   output logic             timeout_out
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam int               SW      = $clog2(SYNC_STAGES + 1);
   localparam logic [SW-1:0]    SETTLED = SW'(SYNC_STAGES);

   logic s_sync, rise, fall;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] counter_q, counter_d;
   logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic [WIDTH-1:0] period_d, high_d;
   logic             valid_d, timeout_d;

   module_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk       (clk),
      .rst       (rst),
      .async_in  (sig_in),
      .level_out (s_sync),
      .rise_out  (rise),
      .fall_out  (fall)
   );

   // State, counters and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_WAIT_LOW;
         counter_q   <= '0;
         high_cnt_q  <= '0;
         settle_q    <= '0;
         period_out  <= '0;
         high_out    <= '0;
         valid_out   <= 1'b0;
         timeout_out <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         high_cnt_q  <= high_cnt_d;
         settle_q    <= settle_d;
         period_out  <= period_d;
         high_out    <= high_d;
         valid_out   <= valid_d;
         timeout_out <= timeout_d;
      end
   end

   // Next-state and next-output logic for the measurement FSM.
   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      high_cnt_d = high_cnt_q;
      settle_d   = settle_q;
      period_d   = period_out;
      high_d     = high_out;
      valid_d    = 1'b0;
      timeout_d  = timeout_out;
      case (state_q)
         S_WAIT_LOW: begin
            // The synchronizer is cleared by reset, so its output reads low
            // until real samples reach it; wait for it to fill before
            // trusting a low level, otherwise a high input at reset
            // release would look like a fresh rising edge.
            counter_d = '0;
            if (settle_q != SETTLED) settle_d = settle_q + SW'(1);
            else if (!s_sync)        state_d  = S_WAIT_EDGE;
         end
         S_WAIT_EDGE: begin
            if (rise) begin
               counter_d  = ONE;
               high_cnt_d = '0;
               state_d    = S_MEASURE;
            end
         end
         S_MEASURE: begin
            counter_d = counter_q + ONE;
            if (fall) high_cnt_d = counter_q;
            if (rise) begin
               period_d   = counter_q;
               high_d     = high_cnt_q;
               valid_d    = 1'b1;
               counter_d  = ONE;
               high_cnt_d = '0;
            end else if (counter_q == MAX_VAL) begin
               timeout_d = 1'b1;
               counter_d = '0;
               state_d   = S_TIMEOUT;
            end
         end
         S_TIMEOUT: begin
            counter_d = '0;
            if (rise) begin
               timeout_d  = 1'b0;
               counter_d  = ONE;
               high_cnt_d = '0;
               state_d    = S_MEASURE;
            end
         end
         default: state_d = S_WAIT_LOW;
      endcase
   end

endmodule

// File: tb/tb_module_period_meter.sv
// Bench for module_period_meter with MAX_COUNT=100. The reference model
// works on the driven waveform only: rise/fall positions, gap arithmetic and
// a fixed pipeline latency, scheduling expected outputs per cycle.
module tb_module_period_meter;

   localparam int MAXC = 100;
   localparam int SYNC = 2;
   localparam int W    = $clog2(MAXC + 1);
   localparam int LAT  = SYNC + 1;
   localparam int N    = 8192;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sig_in = 1'b0;
   logic [W-1:0] period_out, high_out;
   logic         valid_out, timeout_out;

   module_period_meter #(.MAX_COUNT(MAXC), .SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .rst         (rst),
      .sig_in      (sig_in),
      .period_out  (period_out),
      .high_out    (high_out),
      .valid_out   (valid_out),
      .timeout_out (timeout_out)
   );

   // clock
   always #5 clk = ~clk;

   // scheduled expectations, indexed by bench cycle
   bit           ev_valid [N];
   bit           ev_rst   [N];
   bit           ev_tset  [N];
   bit           ev_tclr  [N];
   logic [W-1:0] ev_per   [N];
   logic [W-1:0] ev_high  [N];
   logic [W-1:0] exp_q[$];

   // model state
   bit m_prev, m_seen_low, m_have_rise, m_tmo;
   int m_r, m_hcur;

   // held expected outputs
   logic [W-1:0] hp, hh;
   bit           ht;

   int cyc = 0;
   int checks = 0;
   int fails = 0;
   bit check_en = 1'b0;

   function automatic void model_reset(input int c, input bit lvl);
      int popped;
      popped = 0;
      for (int n = c + 1; n < N; n++) begin
         if (ev_valid[n]) popped++;
         ev_valid[n] = 1'b0;
         ev_rst[n]   = 1'b0;
         ev_tset[n]  = 1'b0;
         ev_tclr[n]  = 1'b0;
      end
      for (int k = 0; k < popped; k++) void'(exp_q.pop_back());
      if (c + 1 < N) ev_rst[c + 1] = 1'b1;
      m_prev      = lvl;
      m_seen_low  = 1'b0;
      m_have_rise = 1'b0;
      m_tmo       = 1'b0;
      m_r         = 0;
      m_hcur      = 0;
   endfunction

   function automatic void model_step(input int c, input bit w);
      bit rise_e, fall_e;
      rise_e = w & ~m_prev;
      fall_e = ~w & m_prev;
      m_prev = w;
      if (!m_seen_low) begin
         if (!w) m_seen_low = 1'b1;
      end else if (rise_e) begin
         if (m_have_rise && !m_tmo) begin
            if (c + LAT < N) begin
               ev_valid[c + LAT] = 1'b1;
               ev_per[c + LAT]   = W'(c - m_r);
               ev_high[c + LAT]  = W'(m_hcur);
               exp_q.push_back(W'(c - m_r));
            end
         end else if (m_tmo) begin
            if (c + LAT < N) ev_tclr[c + LAT] = 1'b1;
         end
         m_have_rise = 1'b1;
         m_r         = c;
         m_hcur      = 0;
         m_tmo       = 1'b0;
      end else begin
         if (fall_e && m_have_rise && !m_tmo) m_hcur = c - m_r;
         if (m_have_rise && !m_tmo && (c - m_r == MAXC)) begin
            m_tmo = 1'b1;
            if (c + LAT < N) ev_tset[c + LAT] = 1'b1;
         end
      end
   endfunction

   task automatic check(input int c);
      logic [W-1:0] e;
      if (!check_en) return;
      if (ev_rst[c]) begin
         hp = '0;
         hh = '0;
         ht = 1'b0;
      end
      if (ev_tset[c]) ht = 1'b1;
      if (ev_tclr[c]) ht = 1'b0;
      if (ev_valid[c]) begin
         hp = ev_per[c];
         hh = ev_high[c];
      end
      checks++;
      assert (valid_out === ev_valid[c]) else begin
         fails++;
         $error("FAIL valid c=%0d observed=%b expected=%b", c, valid_out, ev_valid[c]);
      end
      checks++;
      assert (period_out === hp) else begin
         fails++;
         $error("FAIL period c=%0d observed=%0d expected=%0d", c, period_out, hp);
      end
      checks++;
      assert (high_out === hh) else begin
         fails++;
         $error("FAIL high c=%0d observed=%0d expected=%0d", c, high_out, hh);
      end
      checks++;
      assert (timeout_out === ht) else begin
         fails++;
         $error("FAIL timeout c=%0d observed=%b expected=%b", c, timeout_out, ht);
      end
      if (valid_out === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL sb_empty c=%0d observed=valid expected=no_valid", c);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (period_out === e) else begin
               fails++;
               $error("FAIL sb_period c=%0d observed=%0d expected=%0d", c, period_out, e);
            end
         end
      end
   endtask

   // driver: hold sig_in at lvl for n cycles
   task automatic drive(input bit lvl, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst    = 1'b0;
         sig_in = lvl;
         model_step(cyc, lvl);
         @(negedge clk);
         check(cyc);
         cyc++;
      end
   endtask

   // driver: one-cycle reset with sig_in at lvl
   task automatic pulse_rst(input bit lvl);
      @(posedge clk);
      #1;
      rst    = 1'b1;
      sig_in = lvl;
      model_reset(cyc, lvl);
      @(negedge clk);
      check(cyc);
      check_en = 1'b1;
      cyc++;
   endtask

   task automatic square(input int hi, input int lo, input int reps);
      for (int k = 0; k < reps; k++) begin
         drive(1'b1, hi);
         drive(1'b0, lo);
      end
   endtask

   initial begin
      hp = '0;
      hh = '0;
      ht = 1'b0;
      repeat (3) @(posedge clk);
      pulse_rst(1'b0);
      drive(1'b0, 5);

      // 5 high / 7 low square wave
      square(5, 7, 8);

      // input high across reset release, then 3 high / 9 low
      pulse_rst(1'b1);
      drive(1'b1, 20);
      drive(1'b0, 9);
      square(3, 9, 6);

      // single rise then silence, timeout, recovery with a 40-cycle period
      drive(1'b0, 10);
      drive(1'b1, 5);
      drive(1'b0, 150);
      drive(1'b1, 5);
      drive(1'b0, 35);
      square(5, 35, 2);

      // period exactly MAX_COUNT
      square(50, 50, 4);

      // reset 30 cycles into a measurement
      square(5, 7, 3);
      drive(1'b1, 5);
      drive(1'b0, 25);
      pulse_rst(1'b0);
      drive(1'b0, 6);
      square(5, 7, 4);

      // divider-style input toggling every 11 cycles
      square(11, 11, 5);

      // random high/low widths, some long enough to time out
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, int'($urandom_range(1, 40)));
         drive(1'b0, int'($urandom_range(1, 70)));
      end
      drive(1'b1, 4);
      drive(1'b0, 10);

      checks++;
      assert (exp_q.size() == 0) else begin
         fails++;
         $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
